// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and the
// shift-amount width helper.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_SLTU  = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIV   = 4'd12,
        OP_DIVU  = 4'd13,
        OP_REM   = 4'd14,
        OP_REMU  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Number of low bits of operand B used as the shift amount.
    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU slice: add/sub with carry and overflow, logic ops,
// compares and shifts. Codes from MUL upward produce zero here.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             v
);

    localparam int SH_W = shamt_w(WIDTH);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [SH_W-1:0]  shamt;

    // Select the operation result; carry/overflow only meaningful for ADD/SUB.
    always_comb begin
        is_sub = (op == OP_SUB);
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        shamt  = b[SH_W-1:0];
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                v      = ~(is_sub ^ a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes. Single-cycle ops and divide
// special cases finish on the accept edge; MUL/MULHU use shift-add and
// DIV/DIVU/REM/REMU use restoring division, one bit per cycle.
//
//  state  | meaning
//  IDLE   | waiting for in_valid; in_ready=1
//  MUL    | shift-add iterations, counter WIDTH..1
//  DIV    | restoring-divide iterations, counter WIDTH..1
//  DONE   | result and flags held until out_ready
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] ITERS   = CNT_W'(WIDTH);

    state_e             state;
    alu_op_e            op_in;
    alu_op_e            op_r;
    logic [CNT_W-1:0]   cnt;
    // MUL: {partial product high, multiplier/low product}. DIV: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               neg_q;
    logic               neg_r;

    logic [WIDTH-1:0]   comb_res;
    logic               comb_c;
    logic               comb_v;

    assign op_in = alu_op_e'(op);

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .op     (op_in),
        .a      (a),
        .b      (b),
        .result (comb_res),
        .c      (comb_c),
        .v      (comb_v)
    );

    logic             is_mul_op;
    logic             is_div_op;
    logic             is_sdiv;
    logic             div_zero;
    logic             div_ovf;
    logic             div_special;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] imm_res;
    logic             imm_c;
    logic             imm_v;

    // Classify the incoming op and form the result for anything finishing on accept.
    always_comb begin
        is_mul_op   = (op_in == OP_MUL) || (op_in == OP_MULHU);
        is_div_op   = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        is_sdiv     = (op_in == OP_DIV) || (op_in == OP_REM);
        div_zero    = (b == '0);
        div_ovf     = is_sdiv && (a == MIN_VAL) && (b == '1);
        div_special = is_div_op && (div_zero || div_ovf);
        a_mag       = (is_sdiv && a[WIDTH-1]) ? -a : a;
        b_mag       = (is_sdiv && b[WIDTH-1]) ? -b : b;
        imm_res     = comb_res;
        imm_c       = comb_c;
        imm_v       = comb_v;
        if (is_div_op) begin
            imm_c = 1'b0;
            imm_v = 1'b0;
            if (div_zero) begin
                imm_res = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : a;
            end else begin
                imm_res = (op_in == OP_DIV) ? MIN_VAL : '0;
            end
        end
    end

    logic [WIDTH:0]     mul_hi;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fin_res;

    // One iteration of each datapath, plus the signed/high-half result of the last one.
    always_comb begin
        mul_hi   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_hi, acc[WIDTH-1:1]};
        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, opnd});
        // When div_ge holds the true difference is below opnd, so WIDTH bits suffice.
        div_diff = div_sh[WIDTH-1:0] - opnd;
        div_next = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        quot     = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        rem      = neg_r ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
        fin_res  = '0;
        if (state == S_MUL) begin
            fin_res = (op_r == OP_MUL) ? mul_next[WIDTH-1:0] : mul_next[2*WIDTH-1:WIDTH];
        end else begin
            fin_res = (op_r == OP_DIV || op_r == OP_DIVU) ? quot : rem;
        end
    end

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            z         <= 1'b0;
            n         <= 1'b0;
            c         <= 1'b0;
            v         <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            op_r      <= OP_ADD;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r     <= op_in;
                        in_ready <= 1'b0;
                        if (is_mul_op) begin
                            acc   <= {{WIDTH{1'b0}}, b};
                            opnd  <= a;
                            cnt   <= ITERS;
                            state <= S_MUL;
                        end else if (is_div_op && !div_special) begin
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            opnd  <= b_mag;
                            neg_q <= is_sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r <= is_sdiv && a[WIDTH-1];
                            cnt   <= ITERS;
                            state <= S_DIV;
                        end else begin
                            result    <= imm_res;
                            z         <= (imm_res == '0);
                            n         <= imm_res[WIDTH-1];
                            c         <= imm_c;
                            v         <= imm_v;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= (state == S_MUL) ? mul_next : div_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result    <= fin_res;
                        z         <= (fin_res == '0);
                        n         <= fin_res[WIDTH-1];
                        c         <= 1'b0;
                        v         <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 with an arithmetic reference model
// and a per-cycle output compare process.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         z, n, c, v;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .z         (z),
        .n         (n),
        .c         (c),
        .v         (v)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         z, n, c, v;
        int           lat;
        int           acc_cyc;
        string        name;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    bit           seen = 1'b0;
    logic [W-1:0] last_res = '0;
    logic [3:0]   last_flags = '0;
    int           last_lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        longint      sx, sy, s;
        logic [63:0] ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        e.res = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 1;
        e.acc_cyc = 0; e.name = "";
        case (alu_op_e'(o))
            OP_ADD: begin
                p = ux + uy; e.res = p[31:0]; e.c = (p > 64'hFFFF_FFFF);
                s = sx + sy; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                e.res = x - y; e.c = (x >= y);
                s = sx - sy; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_AND:  e.res = x & y;
            OP_OR:   e.res = x | y;
            OP_XOR:  e.res = x ^ y;
            OP_SLT:  e.res = (sx < sy) ? 32'd1 : 32'd0;
            OP_SLTU: e.res = (x < y) ? 32'd1 : 32'd0;
            OP_SLL:  e.res = x << y[4:0];
            OP_SRL:  e.res = x >> y[4:0];
            OP_SRA:  e.res = 32'(sx >>> y[4:0]);
            OP_MUL:   begin p = ux * uy; e.res = p[31:0];  e.lat = 33; end
            OP_MULHU: begin p = ux * uy; e.res = p[63:32]; e.lat = 33; end
            default: begin
                if (y == 0) begin
                    e.res = (o == OP_DIV || o == OP_DIVU) ? 32'hFFFF_FFFF : x;
                end else if (x == MINV && y == 32'hFFFF_FFFF && o == OP_DIV) begin
                    e.res = MINV;
                end else if (x == MINV && y == 32'hFFFF_FFFF && o == OP_REM) begin
                    e.res = 32'h0;
                end else begin
                    e.lat = 33;
                    case (alu_op_e'(o))
                        OP_DIV:  e.res = 32'(sx / sy);
                        OP_DIVU: e.res = x / y;
                        OP_REM:  e.res = 32'(sx % sy);
                        default: e.res = x % y;
                    endcase
                end
            end
        endcase
        e.z = (e.res == 0);
        e.n = e.res[31];
        return e;
    endfunction

    // Every cycle with out_valid, compare against the oldest outstanding op.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_out: out_valid=1 with nothing outstanding, result=0x%0h", result);
            end else begin
                check({q[0].name, ".result"}, result, q[0].res);
                check({q[0].name, ".flags_znvc"}, 32'({z, n, c, v}), 32'({q[0].z, q[0].n, q[0].c, q[0].v}));
                check({q[0].name, ".in_ready_busy"}, 32'(in_ready), 32'd0);
                if (!seen) begin
                    check({q[0].name, ".latency"}, 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
                    last_lat = cyc - q[0].acc_cyc;
                    seen = 1'b1;
                end
                last_res   = result;
                last_flags = {z, n, c, v};
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   t;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; a = x; b = y;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout: op %0d never accepted, in_ready=%0b", o, in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        e = model(o, x, y);
        e.acc_cyc = cyc;
        e.name = $sformatf("op%0d_%0h_%0h", o, x, y);
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; op = ~o; a = ~x; b = y ^ 32'h5A5A_A5A5;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.timeout: %0d results outstanding, expected 0", nm, q.size());
            q.delete();
            seen = 1'b0;
        end
    endtask

    task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        send(o, x, y);
        drain($sformatf("op%0d", o));
    endtask

    typedef struct { logic [3:0] o; logic [W-1:0] x; logic [W-1:0] y; } vec_t;
    vec_t vecs[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.result", result, 32'h0);
        check("reset.flags", 32'({z, n, c, v}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op(OP_SUB, 32'd5, 32'd7);
        check("sub57.result", last_res, 32'hFFFF_FFFE);
        check("sub57.flags_znvc", 32'(last_flags), 32'b0100);
        check("sub57.latency", 32'(last_lat), 32'd1);
        do_op(OP_SUB, 32'h8000_0000, 32'd1);
        check("submin.result", last_res, 32'h7FFF_FFFF);
        check("submin.flags_znvc", 32'(last_flags), 32'b0011);

        do_op(OP_MUL, 32'hFFFF_FFFF, 32'd2);
        check("mul.result", last_res, 32'hFFFF_FFFE);
        check("mul.latency", 32'(last_lat), 32'd33);
        do_op(OP_MULHU, 32'hFFFF_FFFF, 32'd2);
        check("mulhu.result", last_res, 32'h1);

        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div.result", last_res, 32'hFFFF_FFFD);
        check("div.latency", 32'(last_lat), 32'd33);
        do_op(OP_REM, 32'hFFFF_FFF9, 32'd2);
        check("rem.result", last_res, 32'hFFFF_FFFF);

        do_op(OP_DIVU, 32'd9, 32'd0);
        check("divu0.result", last_res, 32'hFFFF_FFFF);
        check("divu0.latency", 32'(last_lat), 32'd1);
        do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        check("removf.result", last_res, 32'h0);
        check("removf.flags_znvc", 32'(last_flags), 32'b1000);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf.result", last_res, 32'h8000_0000);
        check("divovf.latency", 32'(last_lat), 32'd1);

        vecs = '{
            '{OP_ADD,   32'h7FFF_FFFF, 32'h1},
            '{OP_ADD,   32'hFFFF_FFFF, 32'h1},
            '{OP_SUB,   32'd3,         32'd3},
            '{OP_AND,   32'hF0F0_F0F0, 32'h3C3C_3C3C},
            '{OP_OR,    32'hF0F0_0000, 32'h0000_0F0F},
            '{OP_XOR,   32'hFFFF_0000, 32'hF0F0_F0F0},
            '{OP_SLT,   32'hFFFF_FFFF, 32'h1},
            '{OP_SLTU,  32'hFFFF_FFFF, 32'h1},
            '{OP_SLL,   32'h1,         32'h21},
            '{OP_SRL,   32'h8000_0000, 32'h4},
            '{OP_SRA,   32'h8000_0000, 32'hFFFF_FFE4},
            '{OP_MUL,   32'd12345,     32'd6789},
            '{OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{OP_DIVU,  32'd100,       32'd7},
            '{OP_REMU,  32'd100,       32'd7},
            '{OP_DIV,   32'd7,         32'hFFFF_FFFE},
            '{OP_REM,   32'd7,         32'hFFFF_FFFE},
            '{OP_REMU,  32'd5,         32'd0},
            '{OP_DIV,   32'd0,         32'd5}
        };
        foreach (vecs[i]) do_op(vecs[i].o, vecs[i].x, vecs[i].y);

        // Consumer stalls for 10 cycles while a new request waits.
        out_ready = 1'b0;
        send(OP_XOR, 32'hF0F0_1234, 32'h0FF0_4321);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 50) begin @(negedge clk); t++; end
            check("hold.out_valid_seen", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; op = OP_ADD; a = 32'd3; b = 32'd4;
        repeat (10) begin
            @(negedge clk);
            check("hold.in_ready", 32'(in_ready), 32'd0);
            check("hold.out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold.released_in_ready", 32'(in_ready), 32'd1);
        check("hold.released_out_valid", 32'(out_valid), 32'd0);
        begin
            exp_t e;
            e = model(OP_ADD, 32'd3, 32'd4);
            e.acc_cyc = cyc;
            e.name = "held_add";
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("held_add");
        check("held_add.result", last_res, 32'd7);

        // Reset lands on the 12th divide iteration.
        send(OP_DIV, 32'd1000, 32'd7);
        repeat (11) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        seen = 1'b0;
        @(negedge clk);
        check("midreset.in_ready", 32'(in_ready), 32'd1);
        check("midreset.out_valid", 32'(out_valid), 32'd0);
        check("midreset.result", result, 32'h0);
        check("midreset.flags", 32'({z, n, c, v}), 32'd0);
        repeat (40) @(negedge clk);
        do_op(OP_ADD, 32'd1, 32'd1);
        check("postreset_add.result", last_res, 32'd2);
        check("postreset_add.latency", 32'(last_lat), 32'd1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
